// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;
   localparam int LEN_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Grant select for the memory port mux
   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage, debug-engine and dataMem signals around the arbiter.
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   // CPU MEM stage
   logic             cpu_req;
   logic             cpu_we;
   logic [AW-1:0]    cpu_addr;
   logic [DW-1:0]    cpu_wdata;
   logic [DW-1:0]    cpu_rdata;
   logic             cpu_stall;
   // debug block-transfer engine
   logic             dbg_start;
   logic             dbg_we;
   logic [AW-1:0]    dbg_base;
   logic [LEN_W-1:0] dbg_len;
   logic [DW-1:0]    dbg_wdata;
   logic             dbg_wready;
   logic [DW-1:0]    dbg_rdata;
   logic             dbg_rvalid;
   logic             dbg_busy;
   logic             dbg_done;
   // dataMem port
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic             mem_we;
   logic [DW-1:0]    mem_rdata;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dbg_start, dbg_we, dbg_base, dbg_len, dbg_wdata,
      output dbg_wready, dbg_rdata, dbg_rvalid, dbg_busy, dbg_done,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   // Pipeline / debug engine / memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dbg_start, dbg_we, dbg_base, dbg_len, dbg_wdata,
      input  dbg_wready, dbg_rdata, dbg_rvalid, dbg_busy, dbg_done,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_dbg_burst_ctr.sv
// Debug burst bookkeeping: latches base/len/direction at start, walks the beat
// index and produces the wrapped beat address and the last-beat flag.
module dbg_burst_ctr
   import dmem_arb_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [AW-1:0]    base_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             we_in,
   output logic [AW-1:0]    beat_addr,
   output logic             beat_we,
   output logic             beat_last
);

   logic [AW-1:0]    base_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx;
   logic             we_q;

   // Latch burst parameters on start; advance idx per granted beat, rewind after the last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         len_q  <= '0;
         we_q   <= 1'b0;
         idx    <= '0;
      end else if (load) begin
         base_q <= base_in;
         len_q  <= len_in;
         we_q   <= we_in;
         idx    <= '0;
      end else if (step) begin
         idx <= beat_last ? '0 : idx + LEN_W'(1);
      end
   end

   // Address wraps naturally at AW bits
   assign beat_addr = base_q + AW'(idx);
   assign beat_we   = we_q;
   assign beat_last = (idx == len_q - LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage has priority, the debug
// burst engine gets a forced beat after MAX_WAIT consecutive lost cycles.
//
// state | meaning
// IDLE  | no burst; memory port follows the CPU
// RUN   | burst active; each cycle grants either the CPU or one debug beat
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   state_t        state;
   logic [WCW-1:0] wait_cnt;
   logic          busy_q;
   logic          rvalid_q;
   logic          done_q;
   logic [DW-1:0] rdata_q;

   logic          gnt;
   logic          force_dbg;
   logic          burst_load;
   logic          dbg_beat;
   logic [AW-1:0] beat_addr;
   logic          beat_we;
   logic          beat_last;

   logic [AW-1:0] mux_addr;
   logic [DW-1:0] mux_wdata;
   logic          mux_we;
   logic          mux_stall;
   logic          mux_wready;

   // Starts are only honoured from IDLE, which is where a busy burst cannot be
   assign burst_load = (state == IDLE) && bus.dbg_start && (bus.dbg_len != '0);
   assign dbg_beat   = (gnt == GNT_DBG);

   dbg_burst_ctr #(.AW(AW)) u_burst (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (burst_load),
      .step      (dbg_beat),
      .base_in   (bus.dbg_base),
      .len_in    (bus.dbg_len),
      .we_in     (bus.dbg_we),
      .beat_addr (beat_addr),
      .beat_we   (beat_we),
      .beat_last (beat_last)
   );

   // Grant decision: debug wins when the CPU is quiet or the starvation limit is hit
   always_comb begin
      force_dbg = (wait_cnt == WCW'(MAX_WAIT));
      gnt       = GNT_CPU;
      if (state == RUN && (force_dbg || !bus.cpu_req))
         gnt = GNT_DBG;
   end

   // Memory port mux and CPU stall
   always_comb begin
      mux_addr   = bus.cpu_addr;
      mux_wdata  = bus.cpu_wdata;
      mux_we     = bus.cpu_req & bus.cpu_we;
      mux_stall  = 1'b0;
      mux_wready = 1'b0;
      if (gnt == GNT_DBG) begin
         mux_addr   = beat_addr;
         mux_wdata  = bus.dbg_wdata;
         mux_we     = beat_we;
         mux_stall  = bus.cpu_req;
         mux_wready = beat_we;
      end
   end

   // Burst FSM with wait counter and registered debug outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         busy_q   <= 1'b0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (burst_load) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
               end else if (bus.dbg_start) begin
                  // zero-length burst: acknowledge without touching memory
                  done_q <= 1'b1;
               end
            end
            RUN: begin
               if (dbg_beat) begin
                  wait_cnt <= '0;
                  if (!beat_we) begin
                     rdata_q  <= bus.mem_rdata;
                     rvalid_q <= 1'b1;
                  end
                  if (beat_last) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end else if (!force_dbg) begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr   = mux_addr;
   assign bus.mem_wdata  = mux_wdata;
   assign bus.mem_we     = mux_we;
   assign bus.cpu_stall  = mux_stall;
   assign bus.dbg_wready = mux_wready;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dbg_rdata  = rdata_q;
   assign bus.dbg_rvalid = rvalid_q;
   assign bus.dbg_busy   = busy_q;
   assign bus.dbg_done   = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle control
// expectations and data expectations; a negedge monitor pops and compares.
module tb_dmem_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

   dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // dataMem model: combinational read, write on the clock edge
   logic [7:0] mem [256];
   always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr];

   int checks = 0;
   int errors = 0;
   bit trace_on = 1'b0;

   logic [13:0] exp_tr  [$];
   logic [7:0]  exp_rd  [$];
   logic [15:0] exp_wr  [$];
   logic [7:0]  exp_crd [$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic miss(string name);
      checks++;
      errors++;
      $display("FAIL %s actual=output-present expected=nothing-queued", name);
   endtask

   // {stall, wready, mem_we, rvalid, done, busy, mem_addr}
   function automatic logic [13:0] tr(logic stall, logic wready, logic we, logic rv,
                                      logic done, logic busy, logic [7:0] addr);
      return {stall, wready, we, rv, done, busy, addr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(logic [13:0] e);
      exp_tr.push_back(e);
      tick();
   endtask

   task automatic cpu(logic req, logic we, logic [7:0] addr, logic [7:0] wd);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
   endtask

   task automatic dbg(logic start, logic we, logic [7:0] base, logic [7:0] len);
      bus.dbg_start = start;
      bus.dbg_we    = we;
      bus.dbg_base  = base;
      bus.dbg_len   = len;
   endtask

   // Monitor: per-cycle control trace plus data checks whenever the DUT presents data
   always @(negedge clk) begin
      if (trace_on) begin
         if (exp_tr.size() == 0) miss("trace_underflow");
         else chk("trace{stall,wready,we,rv,done,busy,addr}",
                  {18'd0, bus.cpu_stall, bus.dbg_wready, bus.mem_we, bus.dbg_rvalid,
                   bus.dbg_done, bus.dbg_busy, bus.mem_addr},
                  {18'd0, exp_tr.pop_front()});
      end
      if (bus.dbg_rvalid === 1'b1) begin
         if (exp_rd.size() == 0) miss("dbg_rdata_unexpected");
         else chk("dbg_rdata", {24'd0, bus.dbg_rdata}, {24'd0, exp_rd.pop_front()});
      end
      if (bus.mem_we === 1'b1) begin
         if (exp_wr.size() == 0) miss("mem_write_unexpected");
         else chk("mem_write{addr,data}", {16'd0, bus.mem_addr, bus.mem_wdata},
                  {16'd0, exp_wr.pop_front()});
      end
      if (bus.cpu_req === 1'b1 && bus.cpu_we === 1'b0 && bus.cpu_stall === 1'b0) begin
         if (exp_crd.size() == 0) miss("cpu_read_unexpected");
         else chk("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, exp_crd.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] wv [4];
      logic [7:0] wd [3];
      logic [7:0] wa [3];
      wv = '{8'h11, 8'h22, 8'h33, 8'h44};
      wd = '{8'hC1, 8'hC2, 8'hC3};
      wa = '{8'hFE, 8'hFF, 8'h00};

      cpu(0, 0, 8'h00, 8'h00);
      dbg(0, 0, 8'h00, 8'h00);
      bus.dbg_wdata = 8'h00;
      tick();
      tick();
      chk("rst_busy",   {31'd0, bus.dbg_busy},   0);
      chk("rst_rvalid", {31'd0, bus.dbg_rvalid}, 0);
      chk("rst_done",   {31'd0, bus.dbg_done},   0);
      chk("rst_rdata",  {24'd0, bus.dbg_rdata},  0);
      rst_n    = 1'b1;
      trace_on = 1'b1;

      // 1: CPU-only traffic
      cpu(1, 1, 8'h10, 8'h5A);
      exp_wr.push_back({8'h10, 8'h5A});
      step(tr(0, 0, 1, 0, 0, 0, 8'h10));
      for (int i = 0; i < 4; i++) begin
         cpu(1, 1, 8'h20 + 8'(i), wv[i]);
         exp_wr.push_back({8'h20 + 8'(i), wv[i]});
         step(tr(0, 0, 1, 0, 0, 0, 8'h20 + 8'(i)));
      end
      cpu(1, 0, 8'h10, 8'h00);
      exp_crd.push_back(8'h5A);
      step(tr(0, 0, 0, 0, 0, 0, 8'h10));
      cpu(0, 1, 8'h55, 8'h99);
      step(tr(0, 0, 0, 0, 0, 0, 8'h55));
      cpu(0, 0, 8'h00, 8'h00);

      // 2: debug read len 4 from 0x20, CPU idle
      dbg(1, 0, 8'h20, 8'd4);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(0, 0, 8'h00, 8'd0);
      for (int i = 0; i < 4; i++) exp_rd.push_back(wv[i]);
      step(tr(0, 0, 0, 0, 0, 1, 8'h20));
      step(tr(0, 0, 0, 1, 0, 1, 8'h21));
      step(tr(0, 0, 0, 1, 0, 1, 8'h22));
      step(tr(0, 0, 0, 1, 0, 1, 8'h23));
      step(tr(0, 0, 0, 1, 1, 0, 8'h00));
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));

      // 3: debug read len 3 while CPU reads 0x10 every cycle
      cpu(1, 0, 8'h10, 8'h00);
      dbg(1, 0, 8'h20, 8'd3);
      exp_crd.push_back(8'h5A);
      step(tr(0, 0, 0, 0, 0, 0, 8'h10));
      dbg(0, 0, 8'h00, 8'd0);
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 4; k++) begin
            exp_crd.push_back(8'h5A);
            step(tr(0, 0, 0, (b > 0 && k == 0), 0, 1, 8'h10));
         end
         exp_rd.push_back(wv[b]);
         step(tr(1, 0, 0, 0, 0, 1, 8'h20 + 8'(b)));
      end
      exp_crd.push_back(8'h5A);
      step(tr(0, 0, 0, 1, 1, 0, 8'h10));
      cpu(0, 0, 8'h00, 8'h00);

      // 4: debug write len 3 from 0xFE, wrapping to 0x00
      dbg(1, 1, 8'hFE, 8'd3);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(0, 0, 8'h00, 8'd0);
      for (int i = 0; i < 3; i++) begin
         bus.dbg_wdata = wd[i];
         exp_wr.push_back({wa[i], wd[i]});
         step(tr(0, 1, 1, 0, 0, 1, wa[i]));
      end
      bus.dbg_wdata = 8'h00;
      step(tr(0, 0, 0, 0, 1, 0, 8'h00));
      cpu(1, 0, 8'h00, 8'h00);
      exp_crd.push_back(8'hC3);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      cpu(1, 0, 8'hFE, 8'h00);
      exp_crd.push_back(8'hC1);
      step(tr(0, 0, 0, 0, 0, 0, 8'hFE));
      cpu(0, 0, 8'h00, 8'h00);

      // 5: zero-length burst, start while busy ignored, start on done accepted
      dbg(1, 0, 8'h30, 8'd0);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(0, 0, 8'h00, 8'd0);
      step(tr(0, 0, 0, 0, 1, 0, 8'h00));
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(1, 0, 8'h22, 8'd2);
      exp_rd.push_back(8'h33);
      exp_rd.push_back(8'h44);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(1, 1, 8'h00, 8'd5);
      step(tr(0, 0, 0, 0, 0, 1, 8'h22));
      step(tr(0, 0, 0, 1, 0, 1, 8'h23));
      dbg(1, 0, 8'h20, 8'd1);
      exp_rd.push_back(8'h11);
      step(tr(0, 0, 0, 1, 1, 0, 8'h00));
      dbg(0, 0, 8'h00, 8'd0);
      step(tr(0, 0, 0, 0, 0, 1, 8'h20));
      step(tr(0, 0, 0, 1, 1, 0, 8'h00));

      // 6: reset mid-burst, then a fresh burst
      dbg(1, 0, 8'h20, 8'd4);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(0, 0, 8'h00, 8'd0);
      exp_rd.push_back(8'h11);
      step(tr(0, 0, 0, 0, 0, 1, 8'h20));
      step(tr(0, 0, 0, 1, 0, 1, 8'h21));
      rst_n = 1'b0;
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      chk("midrst_rdata", {24'd0, bus.dbg_rdata}, 0);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      rst_n = 1'b1;
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(1, 0, 8'h22, 8'd2);
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));
      dbg(0, 0, 8'h00, 8'd0);
      exp_rd.push_back(8'h33);
      exp_rd.push_back(8'h44);
      step(tr(0, 0, 0, 0, 0, 1, 8'h22));
      step(tr(0, 0, 0, 1, 0, 1, 8'h23));
      step(tr(0, 0, 0, 1, 1, 0, 8'h00));
      step(tr(0, 0, 0, 0, 0, 0, 8'h00));

      trace_on = 1'b0;
      chk("trace_left",   exp_tr.size(),  0);
      chk("rdata_left",   exp_rd.size(),  0);
      chk("write_left",   exp_wr.size(),  0);
      chk("cpu_rd_left",  exp_crd.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
